// File: rtl/arb_pkg.sv
// Shared constants for the 8-way round-robin arbiter: FSM state encodings,
// requester count and index width, plus a small index helper.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Next requester index with natural 7 -> 0 wrap of the 3-bit field.
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return i + {{(IDX_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/onehot_dec_3_8.sv
// Combinational 3-to-8 one-hot decoder with enable; all-zero when disabled.
module onehot_dec_3_8 (
    input  logic       e,
    input  logic [2:0] din,
    output logic [7:0] dout
);

    // Bit k is set only when enabled and the index selects k.
    always_comb begin
        dout = '0;
        for (int k = 0; k < 8; k++) begin
            dout[k] = e && (din == k[2:0]);
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters. A rotating priority pointer picks the
// first requester at or after ptr; the winner's index is decoded to a one-hot
// grant. Every ownership change passes through a one-cycle GAP, and an
// optional hold timeout revokes a grant that has been held too long.
module rr_arbiter_8 #(
    parameter int N_REQ    = 8,
    parameter int MAX_HOLD = 64,
    parameter int CNT_W    = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] rel,
    output logic [N_REQ-1:0] gnt,
    output logic [2:0]       gnt_idx,
    output logic             gnt_vld,
    output logic             tmo
);

    import arb_pkg::*;

    // Last cycle index at which a grant may still be held, and the saturation
    // ceiling of the hold counter.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_vld_q, gnt_vld_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             tmo_q, tmo_d;

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]   first_off;
    logic [IDX_W-1:0]   winner;
    logic               rel_hit;
    logic               withdraw;
    logic               timeout_hit;
    logic               dec_en;

    // Counter increment that stops at MAX_HOLD; frozen when the timeout is off.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (MAX_HOLD == 0 || v == HOLD_SAT) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Rotate req so ptr lands at bit 0, find the first set bit, then add ptr
    // back to recover the absolute winner index.
    always_comb begin
        req_dbl   = {req, req};
        req_rot   = req_dbl[ptr_q +: N_REQ];
        first_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                first_off = k[IDX_W-1:0];
            end
        end
        winner = ptr_q + first_off;
    end

    // Reasons to end the current grant; only the owner's rel/req bits matter.
    always_comb begin
        rel_hit     = rel[gnt_idx_q];
        withdraw    = !req[gnt_idx_q];
        timeout_hit = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
    end

    // Next-state logic for the FSM, pointer, hold counter and grant index.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_idx_d  = gnt_idx_q;
        gnt_vld_d  = gnt_vld_q;
        tmo_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d    = ST_GRANT;
                    gnt_idx_d  = winner;
                    gnt_vld_d  = 1'b1;
                    ptr_d      = idx_inc(winner);
                    hold_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                hold_cnt_d = sat_inc(hold_cnt_q);
                if (rel_hit || withdraw || timeout_hit) begin
                    state_d   = ST_GAP;
                    gnt_idx_d = '0;
                    gnt_vld_d = 1'b0;
                    // A voluntary release on the same edge is not a forced revoke.
                    tmo_d     = timeout_hit && !rel_hit && !withdraw;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                gnt_idx_d = '0;
                gnt_vld_d = 1'b0;
            end
        endcase
    end

    // Grant vector is the decoded next index, enabled only when entering or
    // staying in GRANT, so gnt always agrees with gnt_vld/gnt_idx.
    always_comb begin
        dec_en = (state_d == ST_GRANT);
    end

    onehot_dec_3_8 u_dec (
        .e    (dec_en),
        .din  (gnt_idx_d),
        .dout (gnt_d)
    );

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_idx_q  <= '0;
            gnt_vld_q  <= 1'b0;
            gnt_q      <= '0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_vld_q  <= gnt_vld_d;
            gnt_q      <= gnt_d;
            tmo_q      <= tmo_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = gnt_vld_q;
    assign tmo     = tmo_q;

endmodule
